// File: rtl/data_mem_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_serial_if
// Description : Request/response bundle between the core data port (master)
//               and the byte-serial data memory (slave). Lane i of the word
//               buses maps to byte address addr+i (lane 0 is the MSB byte).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_serial_if;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [0:3][7:0] req_wdata;
  logic            resp_valid;
  logic [0:3][7:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_serial.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_serial
// Description : Byte-serial word data memory. A word request accepted in IDLE
//               is carried out as four single-byte beats against an internal
//               byte array, optionally separated by BEAT_WAIT idle cycles,
//               followed by a one-cycle response pulse.
//               Optional feature macro: DMEM_MISALIGN_TRAP_EN - misaligned
//               requests skip all beats and answer immediately with resp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_serial #(
  parameter int MEM_BYTES = 4096,
  parameter int BEAT_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_b,
  data_mem_serial_if.slave bus
);

  localparam int         AW        = $clog2(MEM_BYTES);
  localparam logic [3:0] WAIT_LAST = (BEAT_WAIT > 0) ? 4'(BEAT_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state, state_d;
  // beat counts 0..4; bit 2 marks that all four beats are done, which lets a
  // WAIT phase follow the last beat as well as the earlier ones.
  logic [2:0]      beat, beat_d;
  logic [3:0]      wait_cnt, wait_cnt_d;

  logic            accept;
  logic            trap;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [0:3][7:0] wdata_q;
  logic [0:3][7:0] rdata_q;
  logic [AW-1:0]   idx;
  logic [7:0]      mem [MEM_BYTES];

  // Address bits above the array index are intentionally ignored.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW];

  assign accept = bus.req_valid && (state == S_IDLE);
  // Natural AW-bit wrap gives the modulo-MEM_BYTES byte index.
  assign idx    = addr_q + AW'(beat[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  assign trap           = (bus.req_addr[1:0] != 2'b00);
  assign bus.resp_err   = (state == S_RESP) && err_q;
  assign bus.resp_rdata = ((state == S_RESP) && err_q) ? '0 : rdata_q;

  // Remember whether the accepted request was trapped.
  always_ff @(posedge clk) begin
    if (rst_b)       err_q <= 1'b0;
    else if (accept) err_q <= trap;
  end
`else
  assign trap           = 1'b0;
  assign bus.resp_err   = 1'b0;
  assign bus.resp_rdata = rdata_q;
`endif

  // State and counter registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state    <= S_IDLE;
      beat     <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      beat     <= beat_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_d        = state;
    beat_d         = beat;
    wait_cnt_d     = wait_cnt;
    bus.req_ready  = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    case (state)
      S_IDLE: begin
        if (accept) begin
          beat_d     = '0;
          wait_cnt_d = '0;
          state_d    = trap ? S_RESP : S_BEAT;
        end
      end
      S_BEAT: begin
        beat_d     = beat + 3'd1;
        wait_cnt_d = '0;
        if (BEAT_WAIT != 0)          state_d = S_WAIT;
        else if (beat[1:0] == 2'd3)  state_d = S_RESP;
        else                         state_d = S_BEAT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = beat[2] ? S_RESP : S_BEAT;
        end else begin
          wait_cnt_d = wait_cnt + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched request copy used for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr[AW-1:0];
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata;
    end
  end

  // Read lanes fill one byte per beat and otherwise hold their value.
  always_ff @(posedge clk) begin
    if (rst_b)                             rdata_q <= '0;
    else if ((state == S_BEAT) && !we_q)   rdata_q[beat[1:0]] <= mem[idx];
  end

  // Byte array write port; contents survive reset, but a reset edge blocks the beat.
  always_ff @(posedge clk) begin
    if (!rst_b && (state == S_BEAT) && we_q) mem[idx] <= wdata_q[beat[1:0]];
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_serial
// Description : Self-checking bench for data_mem_serial. Two instances: one
//               with default parameters (scoreboard-checked against a byte
//               model), one with BEAT_WAIT=2 for wait-state timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_serial;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  data_mem_serial_if bus0 ();
  data_mem_serial_if bus2 ();

  data_mem_serial #(.MEM_BYTES(4096), .BEAT_WAIT(0)) u_dut0 (.clk(clk), .rst_b(rst_b), .bus(bus0));
  data_mem_serial #(.MEM_BYTES(4096), .BEAT_WAIT(2)) u_dut2 (.clk(clk), .rst_b(rst_b), .bus(bus2));

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  mask;   // bit 3 = lane 0
    logic        err;
    int          lat;
  } rec_t;

  rec_t exp_q[$];
  rec_t act_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt0 = 0;

  logic [7:0] ref_mem   [4096];
  logic       ref_known [4096];

  // Count response pulses of the default instance.
  always @(negedge clk) if (bus0.resp_valid === 1'b1) resp_cnt0 = resp_cnt0 + 1;

  function automatic logic [31:0] lane_mask(input logic [3:0] mk);
    return {{8{mk[3]}}, {8{mk[2]}}, {8{mk[1]}}, {8{mk[0]}}};
  endfunction

  // Model: compute the expected response for a request and update the byte model.
  task automatic expect_push(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    rec_t e;
    logic [11:0] a;
    e.rdata = '0; e.mask = '0; e.err = 1'b0; e.lat = 5;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1; e.lat = 1; e.mask = 4'hF;
      exp_q.push_back(e);
      return;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      a = addr[11:0] + 12'(i);
      if (we) begin
        ref_mem[a]   = wd[31-8*i -: 8];
        ref_known[a] = 1'b1;
      end else if (ref_known[a]) begin
        e.rdata[31-8*i -: 8] = ref_mem[a];
        e.mask[3-i] = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  // Drive one request on bus0 and record the observed response.
  task automatic xfer0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    rec_t r;
    int k;
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    k = 0;
    while (bus0.req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = $urandom;
    k = 0;
    while (bus0.resp_valid !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    r.rdata = bus0.resp_rdata;
    r.err   = bus0.resp_err;
    r.mask  = '0;
    r.lat   = (bus0.resp_valid === 1'b1) ? k + 1 : -1;
    act_q.push_back(r);
  endtask

  task automatic test_reset;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b want 1", bus0.req_ready); end
    n_checks++; if (bus0.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", bus0.resp_valid); end
    n_checks++; if (bus0.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err0: got %b want 0", bus0.resp_err); end
    n_checks++; if (bus0.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h want 00000000", bus0.resp_rdata); end
    n_checks++; if (bus2.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready2: got %b want 1", bus2.req_ready); end
    n_checks++; if (bus2.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b want 0", bus2.resp_valid); end
  endtask

  task automatic test_write_read;
    rec_t e, a;
    logic [31:0] m;
    expect_push(1'b1, 32'h0000_0100, 32'hDEAD_BEEF); xfer0(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    expect_push(1'b0, 32'h0000_0100, 32'h0);         xfer0(1'b0, 32'h0000_0100, 32'h0);
    expect_push(1'b0, 32'hABCD_E100, 32'h0);         xfer0(1'b0, 32'hABCD_E100, 32'h0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); m = lane_mask(e.mask);
      n_checks++;
      if (a.lat !== e.lat || a.err !== e.err || (a.rdata & m) !== (e.rdata & m)) begin
        n_fail++;
        $display("FAIL write_read: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h mask=%h",
                 a.lat, a.err, a.rdata, e.lat, e.err, e.rdata, m);
      end
    end
    n_checks++; if (exp_q.size() != act_q.size()) begin n_fail++; $display("FAIL write_read_count: exp %0d act %0d", exp_q.size(), act_q.size()); end
  endtask

  task automatic test_wait_states;
    int k, low;
    for (int t = 0; t < 2; t++) begin
      bus2.req_valid = 1'b1;
      bus2.req_we    = (t == 0);
      bus2.req_addr  = 32'h0000_0040;
      bus2.req_wdata = 32'h0102_0304;
      k = 0;
      while (bus2.req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      bus2.req_valid = 1'b0;
      k = 0; low = 0;
      while (bus2.resp_valid !== 1'b1 && k < 100) begin
        if (bus2.req_ready === 1'b0) low++;
        @(posedge clk); #1; k++;
      end
      if (bus2.req_ready === 1'b0) low++;
      n_checks++; if (bus2.resp_valid !== 1'b1 || k + 1 != 13) begin n_fail++; $display("FAIL wait_latency[%0d]: got %0d want 13", t, k + 1); end
      n_checks++; if (low != 13) begin n_fail++; $display("FAIL wait_ready_low[%0d]: got %0d cycles want 13", t, low); end
      if (t == 1) begin
        n_checks++; if (bus2.resp_rdata !== 32'h0102_0304) begin n_fail++; $display("FAIL wait_rdata: got %h want 01020304", bus2.resp_rdata); end
        n_checks++; if (bus2.resp_err !== 1'b0) begin n_fail++; $display("FAIL wait_err: got %b want 0", bus2.resp_err); end
      end
    end
  endtask

  task automatic test_wrap;
    rec_t e, a;
    logic [31:0] m;
    expect_push(1'b1, 32'h0000_0FFE, 32'h1122_3344); xfer0(1'b1, 32'h0000_0FFE, 32'h1122_3344);
    expect_push(1'b0, 32'h0000_0FFE, 32'h0);         xfer0(1'b0, 32'h0000_0FFE, 32'h0);
    expect_push(1'b0, 32'h0000_0000, 32'h0);         xfer0(1'b0, 32'h0000_0000, 32'h0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); m = lane_mask(e.mask);
      n_checks++;
      if (a.lat !== e.lat || a.err !== e.err || (a.rdata & m) !== (e.rdata & m)) begin
        n_fail++;
        $display("FAIL wrap: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h mask=%h",
                 a.lat, a.err, a.rdata, e.lat, e.err, e.rdata, m);
      end
    end
    n_checks++; if (exp_q.size() != act_q.size()) begin n_fail++; $display("FAIL wrap_count: exp %0d act %0d", exp_q.size(), act_q.size()); end
  endtask

  task automatic test_hold_valid;
    rec_t e, a;
    logic [31:0] m;
    int k, c0;
    c0 = resp_cnt0;
    expect_push(1'b0, 32'h0000_0100, 32'h0);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h0000_0100;
    k = 0;
    while (bus0.req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    k = 0;
    while (bus0.resp_valid !== 1'b1 && k < 100) begin
      bus0.req_addr = $urandom;
      @(posedge clk); #1; k++;
    end
    a.rdata = bus0.resp_rdata; a.err = bus0.resp_err; a.mask = '0;
    a.lat = (bus0.resp_valid === 1'b1) ? k + 1 : -1;
    act_q.push_back(a);
    bus0.req_addr = 32'h0000_0200;
    expect_push(1'b0, 32'h0000_0200, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_after_resp: got %b want 1", bus0.req_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus0.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_next_accept: ready got %b want 0", bus0.req_ready); end
    bus0.req_valid = 1'b0;
    k = 0;
    while (bus0.resp_valid !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    a.rdata = bus0.resp_rdata; a.err = bus0.resp_err; a.mask = '0;
    a.lat = (bus0.resp_valid === 1'b1) ? k + 1 : -1;
    act_q.push_back(a);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); m = lane_mask(e.mask);
      n_checks++;
      if (a.lat !== e.lat || a.err !== e.err || (a.rdata & m) !== (e.rdata & m)) begin
        n_fail++;
        $display("FAIL hold_valid: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h mask=%h",
                 a.lat, a.err, a.rdata, e.lat, e.err, e.rdata, m);
      end
    end
    @(negedge clk);
    n_checks++; if (resp_cnt0 - c0 != 2) begin n_fail++; $display("FAIL hold_resp_count: got %0d want 2", resp_cnt0 - c0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write;
    rec_t e, a;
    logic [31:0] m;
    int k, c0;
    expect_push(1'b1, 32'h0000_0200, 32'h0); xfer0(1'b1, 32'h0000_0200, 32'h0);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h0000_0200; bus0.req_wdata = 32'hA1B2_C3D4;
    k = 0;
    while (bus0.req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    c0 = resp_cnt0;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus0.req_ready); end
    n_checks++; if (bus0.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 00000000", bus0.resp_rdata); end
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (resp_cnt0 != c0) begin n_fail++; $display("FAIL midrst_no_resp: got %0d pulses want 0", resp_cnt0 - c0); end
    ref_mem[12'h200] = 8'hA1;
    ref_mem[12'h201] = 8'hB2;
    expect_push(1'b0, 32'h0000_0200, 32'h0); xfer0(1'b0, 32'h0000_0200, 32'h0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); m = lane_mask(e.mask);
      n_checks++;
      if (a.lat !== e.lat || a.err !== e.err || (a.rdata & m) !== (e.rdata & m)) begin
        n_fail++;
        $display("FAIL reset_mid_write: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h mask=%h",
                 a.lat, a.err, a.rdata, e.lat, e.err, e.rdata, m);
      end
    end
  endtask

  task automatic test_misalign;
    rec_t e, a;
    logic [31:0] m;
    expect_push(1'b1, 32'h0000_0104, 32'h0);         xfer0(1'b1, 32'h0000_0104, 32'h0);
    expect_push(1'b1, 32'h0000_0101, 32'h0102_0304); xfer0(1'b1, 32'h0000_0101, 32'h0102_0304);
    expect_push(1'b0, 32'h0000_0100, 32'h0);         xfer0(1'b0, 32'h0000_0100, 32'h0);
    expect_push(1'b1, 32'h0000_0102, 32'h5566_7788); xfer0(1'b1, 32'h0000_0102, 32'h5566_7788);
    expect_push(1'b0, 32'h0000_0100, 32'h0);         xfer0(1'b0, 32'h0000_0100, 32'h0);
    expect_push(1'b0, 32'h0000_0104, 32'h0);         xfer0(1'b0, 32'h0000_0104, 32'h0);
    expect_push(1'b0, 32'h0000_0103, 32'h0);         xfer0(1'b0, 32'h0000_0103, 32'h0);
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); m = lane_mask(e.mask);
      n_checks++;
      if (a.lat !== e.lat || a.err !== e.err || (a.rdata & m) !== (e.rdata & m)) begin
        n_fail++;
        $display("FAIL misalign: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h mask=%h",
                 a.lat, a.err, a.rdata, e.lat, e.err, e.rdata, m);
      end
    end
    n_checks++; if (exp_q.size() != act_q.size()) begin n_fail++; $display("FAIL misalign_count: exp %0d act %0d", exp_q.size(), act_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_known[i] = 1'b0;
      ref_mem[i]   = 8'h00;
    end
    test_reset();
    test_write_read();
    test_wait_states();
    test_wrap();
    test_hold_valid();
    test_reset_mid_write();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
